// File: rtl/bo_datapath_pkg.sv
// Shared definitions for the polynomial-evaluation datapath.
// Holds the default data width, the mux select encodings and the ALU op encoding.
package bo_datapath_pkg;

  localparam int WIDTH_DEF = 16;

  // Coefficient mux: selects a constant operand source.
  typedef enum logic [1:0] {
    M0_ZERO = 2'b00,
    M0_A    = 2'b01,
    M0_B    = 2'b10,
    M0_C    = 2'b11
  } m0_sel_e;

  // ALU operand-1 select.
  typedef enum logic [1:0] {
    M1_MUX = 2'b00,
    M1_R0  = 2'b01,
    M1_R2  = 2'b10,
    M1_R1  = 2'b11
  } m1_sel_e;

  // ALU operand-2 select.
  typedef enum logic [1:0] {
    M2_R0  = 2'b00,
    M2_MUX = 2'b01,
    M2_R2  = 2'b10,
    M2_R1  = 2'b11
  } m2_sel_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_e;

endpackage

// File: rtl/bo_datapath_if.sv
// Control/data bundle between a sequencing controller (master) and the datapath (slave).
//   A, B, C, x    : coefficients and polynomial variable (WIDTH bits)
//   M0, M1, M2    : mux selects
//   LX, LH, LS    : load enables for R0, R1, R2
//   H             : ALU op (0 add, 1 multiply)
//   Pronto        : current R2 contents (datapath output)
interface bo_datapath_if
  import bo_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] A, B, C, x;
  logic [1:0]       M0, M1, M2;
  logic             LX, LH, LS, H;
  logic [WIDTH-1:0] Pronto;

  modport master (output A, B, C, x, M0, M1, M2, LX, LH, LS, H, input Pronto);
  modport slave  (input  A, B, C, x, M0, M1, M2, LX, LH, LS, H, output Pronto);
endinterface

// File: rtl/bo_datapath_registrador.sv
// registrador: WIDTH-bit register with synchronous active-high clear and load enable.
//   clk  : rising-edge clock
//   rst  : synchronous clear, wins over i_ld
//   i_ld : load enable
//   i_d  : data in
//   o_q  : registered value
module registrador
  import bo_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/bo_datapath.sv
// bo_datapath: register/ALU datapath that evaluates A*x^2 + B*x + C when driven by
// an external controller. No internal sequencing: every cycle is steered by the bus.
//   clk : rising-edge clock
//   rst : synchronous active-high clear of R0/R1/R2
//   bus : bo_datapath_if.slave (coefficients, selects, load enables, op, Pronto out)
module bo_datapath
  import bo_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  bo_datapath_if.slave   bus
);
  // Register index: 0 = R0 (x), 1 = R1 (partial), 2 = R2 (result)
  logic [2:0]            w_ld;
  logic [2:0][WIDTH-1:0] w_d, w_q;
  logic [WIDTH-1:0]      w_m0, w_op1, w_op2, w_alu;

  always_comb begin
    w_m0 = '0;
    case (bus.M0)
      M0_ZERO: w_m0 = '0;
      M0_A:    w_m0 = bus.A;
      M0_B:    w_m0 = bus.B;
      M0_C:    w_m0 = bus.C;
      default: w_m0 = '0;
    endcase
  end

  always_comb begin
    w_op1 = w_m0;
    case (bus.M1)
      M1_MUX:  w_op1 = w_m0;
      M1_R0:   w_op1 = w_q[0];
      M1_R2:   w_op1 = w_q[2];
      M1_R1:   w_op1 = w_q[1];
      default: w_op1 = w_m0;
    endcase
  end

  always_comb begin
    w_op2 = w_q[0];
    case (bus.M2)
      M2_R0:   w_op2 = w_q[0];
      M2_MUX:  w_op2 = w_m0;
      M2_R2:   w_op2 = w_q[2];
      M2_R1:   w_op2 = w_q[1];
      default: w_op2 = w_q[0];
    endcase
  end

  // Result width is context-determined by w_alu, so both ops wrap modulo 2^WIDTH.
  always_comb begin
    if (bus.H == OP_MUL) w_alu = w_op1 * w_op2;
    else                 w_alu = w_op1 + w_op2;
  end

  // R1 and R2 share the ALU result, so LH+LS together capture the same value.
  assign w_d  = {w_alu, w_alu, bus.x};
  assign w_ld = {bus.LS, bus.LH, bus.LX};

  for (genvar g = 0; g < 3; g++) begin : g_reg
    registrador #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .i_ld (w_ld[g]),
      .i_d  (w_d[g]),
      .o_q  (w_q[g])
    );
  end

  assign bus.Pronto = w_q[2];
endmodule

// File: tb/tb_bo_datapath.sv
// Testbench for bo_datapath: a table of directed vectors (reset, full polynomial
// sequence, zero select, truncation, hold/priority, simultaneous load) followed by
// randomized cycles checked against a lookup-based behavioural model.
module tb_bo_datapath;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bo_datapath_if #(.WIDTH(W)) bus ();
  bo_datapath #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic         rst;
    logic [W-1:0] x;
    logic [1:0]   m0, m1, m2;
    logic         h, lx, lh, ls;
    logic [W-1:0] exp_p;
    logic         chk_r1;
    logic [W-1:0] exp_r1;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t V(input logic r, input logic [W-1:0] x,
                             input logic [1:0] m0, m1, m2,
                             input logic h, lx, lh, ls,
                             input logic [W-1:0] ep,
                             input logic cr1, input logic [W-1:0] er1);
    vec_t v;
    v.rst = r; v.x = x; v.m0 = m0; v.m1 = m1; v.m2 = m2;
    v.h = h; v.lx = lx; v.lh = lh; v.ls = ls;
    v.exp_p = ep; v.chk_r1 = cr1; v.exp_r1 = er1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; bus.x = v.x;
    bus.M0 = v.m0; bus.M1 = v.m1; bus.M2 = v.m2;
    bus.H = v.h; bus.LX = v.lx; bus.LH = v.lh; bus.LS = v.ls;
  endtask

  // Behavioural model state
  logic [W-1:0] m_r0, m_r1, m_r2;

  function automatic logic [W-1:0] model_alu(input logic [W-1:0] a, b, c,
                                             input logic [1:0] m0, m1, m2, input logic h);
    logic [W-1:0] coef [4];
    logic [W-1:0] o1 [4];
    logic [W-1:0] o2 [4];
    longint unsigned res;
    coef = '{16'd0, a, b, c};
    o1   = '{coef[m0], m_r0, m_r2, m_r1};
    o2   = '{m_r0, coef[m0], m_r2, m_r1};
    res  = h ? longint'(o1[m1]) * longint'(o2[m2]) : longint'(o1[m1]) + longint'(o2[m2]);
    return W'(res % 65536);
  endfunction

  initial begin
    rst = 1'b0;
    bus.A = 16'd2; bus.B = 16'd2; bus.C = 16'd1; bus.x = '0;
    bus.M0 = '0; bus.M1 = '0; bus.M2 = '0;
    bus.H = 1'b0; bus.LX = 1'b0; bus.LH = 1'b0; bus.LS = 1'b0;

    //                 rst x        m0 m1 m2  h  lx lh ls  Pronto   chkR1 R1
    tbl.push_back(V(1, 16'd0,    0, 0, 0, 0, 0, 0, 0, 16'd0,    1, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 16'd0,    1, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 16'd0,    0, 16'd0));
    // Polynomial 2*x^2 + 2*x + 1 at x=2
    tbl.push_back(V(0, 16'd2,    0, 0, 0, 0, 1, 0, 0, 16'd0,    0, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 1, 0, 1, 0, 1, 0, 16'd0,    1, 16'd4));
    tbl.push_back(V(0, 16'd0,    1, 0, 3, 1, 0, 1, 0, 16'd0,    1, 16'd8));
    tbl.push_back(V(0, 16'd0,    2, 0, 0, 1, 0, 0, 1, 16'd4,    1, 16'd8));
    tbl.push_back(V(0, 16'd0,    0, 2, 3, 0, 0, 1, 0, 16'd4,    1, 16'd12));
    tbl.push_back(V(0, 16'd0,    3, 0, 3, 0, 0, 0, 1, 16'd13,   1, 16'd12));
    // Hold five cycles, then reset with LS high
    for (int i = 0; i < 5; i++)
      tbl.push_back(V(0, 16'd0,  3, 0, 3, 0, 0, 0, 0, 16'd13,   0, 16'd0));
    tbl.push_back(V(1, 16'd0,    3, 0, 3, 0, 0, 1, 1, 16'd0,    1, 16'd0));
    // Zero-select path
    tbl.push_back(V(0, 16'd7,    0, 0, 0, 0, 1, 0, 0, 16'd0,    0, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 16'd7,    0, 16'd0));
    // Truncation: mul and add overflow
    tbl.push_back(V(0, 16'h0100, 0, 0, 0, 0, 1, 0, 0, 16'd7,    0, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 1, 0, 1, 0, 0, 1, 16'h0000, 0, 16'd0));
    tbl.push_back(V(0, 16'hFFFF, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 1, 0, 0, 0, 0, 1, 16'hFFFE, 0, 16'd0));
    // Simultaneous LH+LS with ALU = 0 + R0 = 9
    tbl.push_back(V(0, 16'd9,    0, 0, 0, 0, 1, 0, 0, 16'hFFFE, 0, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 0, 0, 0, 0, 1, 1, 16'd9,    1, 16'd9));
    // Reset beats LX/LH/LS; R0 is then observed as zero through the zero-select path
    tbl.push_back(V(1, 16'd5,    0, 0, 0, 0, 1, 1, 1, 16'd0,    1, 16'd0));
    tbl.push_back(V(0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 16'd0,    1, 16'd0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      chk("pronto", i, bus.Pronto, tbl[i].exp_p);
      if (tbl[i].chk_r1) chk("r1", i, dut.w_q[1], tbl[i].exp_r1);
    end

    // Randomized phase; model starts from a fresh reset.
    rst = 1'b1; bus.LX = 0; bus.LH = 0; bus.LS = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_r0 = '0; m_r1 = '0; m_r2 = '0;
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] alu;
      bus.A  = W'($urandom); bus.B = W'($urandom); bus.C = W'($urandom);
      bus.x  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      bus.M0 = 2'($urandom); bus.M1 = 2'($urandom); bus.M2 = 2'($urandom);
      bus.H  = 1'($urandom); bus.LX = 1'($urandom); bus.LH = 1'($urandom); bus.LS = 1'($urandom);
      rst    = ($urandom_range(0, 19) == 0);
      alu = model_alu(bus.A, bus.B, bus.C, bus.M0, bus.M1, bus.M2, bus.H);
      @(posedge clk); #1;
      if (rst) begin
        m_r0 = '0; m_r1 = '0; m_r2 = '0;
      end else begin
        if (bus.LX) m_r0 = bus.x;
        if (bus.LH) m_r1 = alu;
        if (bus.LS) m_r2 = alu;
      end
      chk("rnd_pronto", n, bus.Pronto, m_r2);
      chk("rnd_r1", n, dut.w_q[1], m_r1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bo_datapath.md
BO_DATAPATH -- requirements
Module: bo_datapath

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 16, data width of all operands, registers and the output.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 A  input  WIDTH  coefficient A.
REQ-006 B  input  WIDTH  coefficient B.
REQ-007 C  input  WIDTH  coefficient C.
REQ-008 x  input  WIDTH  polynomial variable.
REQ-009 M0  input  2  coefficient mux select: 00=zero, 01=A, 10=B, 11=C.
REQ-010 M1  input  2  ALU operand-1 select: 00=M0 output, 01=R0, 10=R2, 11=R1.
REQ-011 M2  input  2  ALU operand-2 select: 00=R0, 01=M0 output, 10=R2, 11=R1.
REQ-012 LX  input  1  load enable for R0 (x register).
REQ-013 LH  input  1  load enable for R1 (partial-result register).
REQ-014 LS  input  1  load enable for R2 (result register).
REQ-015 H  input  1  ALU operation: 0=add, 1=multiply.
REQ-016 Pronto  output  WIDTH  current R2 contents.

Function
REQ-017 The three multiplexers and the ALU SHALL be purely combinational, with no clock dependence and zero-cycle latency.
REQ-018 The ALU output SHALL equal op1+op2 when H=0 and op1*op2 when H=1, truncated to the low WIDTH bits (modulo 2^WIDTH, unsigned, no saturation or flags).
REQ-019 R0 SHALL load x on a rising clk edge when LX=1, and otherwise hold its value.
REQ-020 R1 SHALL load the ALU output on a rising clk edge when LH=1, and otherwise hold its value.
REQ-021 R2 SHALL load the ALU output on a rising clk edge when LS=1, and otherwise hold its value.
REQ-022 When LH=1 and LS=1 together, both R1 and R2 SHALL capture the same ALU value on that edge.
REQ-023 Register inputs SHALL be sampled from values settled before the edge, so a register read and written in the same cycle supplies its old value to the ALU.
REQ-024 Pronto SHALL be driven directly from R2, so a new value appears one clock edge after LS=1 is sampled.
REQ-025 The datapath SHALL evaluate A*x^2 + B*x + C under this controller sequence, with one state per clock:
- load x (LX);
- x*x into R1 (M1=01, M2=00, H=1, LH);
- A*R1 into R1 (M0=01, M1=00, M2=11, H=1, LH);
- B*x into R2 (M0=10, M1=00, M2=00, H=1, LS);
- R2+R1 into R1 (M1=10, M2=11, H=0, LH);
- C+R1 into R2 (M0=11, M1=00, M2=11, H=0, LS).
REQ-026 The block SHALL contain no internal FSM; all sequencing comes from the control inputs.

Reset
REQ-027 When rst=1 at a rising edge, R0, R1 and R2 SHALL clear to 0, so Pronto=0.
REQ-028 Reset SHALL take priority over LX, LH and LS asserted in the same cycle.
REQ-029 Reset asserted mid-sequence SHALL discard all partial results, and the combinational paths SHALL remain active during reset.

Structure
REQ-030 A shared package SHALL hold the WIDTH default, the M0/M1/M2 select encodings and the H op encoding (ADD=0, MUL=1).
REQ-031 One sub-module, registrador, SHALL be instantiated three times: a WIDTH-bit register with clk, rst and load enable.
REQ-032 The multiplexers and the ALU SHALL be written inline in bo_datapath.

Verification
REQ-033 Reset check: rst=1 for one edge, then all enables 0 -> Pronto=0 and stays 0.
REQ-034 Polynomial check: A=2, B=2, C=1, x=2, full REQ-025 sequence -> Pronto=13 after the final LS edge, with intermediate R1 values 4, 8, 12.
REQ-035 Zero-select path: x=7 loaded, then M0=00, M1=00, M2=00, H=0, LS=1 -> Pronto=7.
REQ-036 Truncation: x=0x0100 loaded, then M1=01, M2=00, H=1, LS=1 -> Pronto=0x0000; with x=0xFFFF and add (H=0) -> Pronto=0xFFFE.
REQ-037 Hold and priority: Pronto=13, then LS=0 for 5 cycles -> stays 13; then rst=1 with LS=1 -> Pronto=0.
REQ-038 Simultaneous load: LH=1 and LS=1 with ALU=9 -> R1=9 and Pronto=9 after one edge.
